fmul_seq: RTL and testbench

- Parametrised, sequential successor to the combinational 8-bit fractional multiplier.
- Covers all six AVR-style multiply modes in one block: MUL, MULS, MULSU, FMUL, FMULS, FMULSU.
- Iterative shift-add datapath; one operand pair in flight; valid/ready handshakes on both sides.
- Sits between the ALU operand latch and the register-file writeback, returning the high/low result words plus C and Z flags.

---
 rtl/fmul_seq.sv | 148 ++++++++++++++
 tb/tb_fmul_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_seq.sv
// fmul_seq: iterative shift-add multiplier covering MUL, MULS, MULSU, FMUL, FMULS, FMULSU.
// Optional macro FMUL_SAT_EN: FMULS of most-negative x most-negative saturates instead of wrapping.
module fmul_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_rd,
  input  logic [WIDTH-1:0] i_rr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_r1,
  output logic [WIDTH-1:0] o_r0,
  output logic             o_c,
  output logic             o_z
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic             frac;

`ifdef FMUL_SAT_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic sat;
  logic sat_hit_c;
`endif

  logic             rd_signed_c;
  logic             rr_signed_c;
  logic             rd_neg_c;
  logic             rr_neg_c;
  logic [WIDTH-1:0] rd_mag_c;
  logic [WIDTH-1:0] rr_mag_c;
  logic [PW-1:0]    acc_next_c;
  logic [PW-1:0]    prod_c;
  logic [PW-1:0]    res_c;

  // Operand decode: reserved mode 11 falls through to unsigned x unsigned.
  always_comb begin
    rd_signed_c = (i_mode[1:0] == 2'b01) || (i_mode[1:0] == 2'b10);
    rr_signed_c = (i_mode[1:0] == 2'b01);
    rd_neg_c    = rd_signed_c && i_rd[WIDTH-1];
    rr_neg_c    = rr_signed_c && i_rr[WIDTH-1];
    rd_mag_c    = rd_neg_c ? WIDTH'(~i_rd + WIDTH'(1)) : i_rd;
    rr_mag_c    = rr_neg_c ? WIDTH'(~i_rr + WIDTH'(1)) : i_rr;
  end

`ifdef FMUL_SAT_EN
  always_comb begin
    sat_hit_c = (i_mode == 3'b101) && (i_rd == MOST_NEG) && (i_rr == MOST_NEG);
  end
`endif

  // One shift-add step plus the sign / fractional-shift post-processing of its result.
  always_comb begin
    acc_next_c = acc + (mplier[0] ? mcand : '0);
    prod_c     = neg ? PW'(~acc_next_c + PW'(1)) : acc_next_c;
    res_c      = frac ? {prod_c[PW-2:0], 1'b0} : prod_c;
`ifdef FMUL_SAT_EN
    if (sat) begin
      res_c = {1'b0, {(PW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_r1    <= '0;
      o_r0    <= '0;
      o_c     <= 1'b0;
      o_z     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      frac    <= 1'b0;
`ifdef FMUL_SAT_EN
      sat     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            state   <= BUSY;
            o_ready <= 1'b0;
            acc     <= '0;
            mcand   <= PW'(rd_mag_c);
            mplier  <= rr_mag_c;
            neg     <= rd_neg_c ^ rr_neg_c;
            frac    <= i_mode[2];
            cnt     <= '0;
`ifdef FMUL_SAT_EN
            sat     <= sat_hit_c;
`endif
          end
        end
        BUSY: begin
          acc    <= acc_next_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Final iteration: register the finished result directly from the step logic.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_r1    <= res_c[PW-1:WIDTH];
            o_r0    <= res_c[WIDTH-1:0];
            o_c     <= prod_c[PW-1];
            o_z     <= (res_c == '0);
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_seq.sv
// tb_fmul_seq: self-checking bench for fmul_seq (WIDTH=8) against an integer-arithmetic reference.
module tb_fmul_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [2:0]   i_mode = 3'b000;
  logic [W-1:0] i_rd = '0;
  logic [W-1:0] i_rr = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_r1;
  logic [W-1:0] o_r0;
  logic         o_c;
  logic         o_z;

  int tests = 0;
  int fails = 0;

  fmul_seq #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_mode (i_mode),
    .i_rd   (i_rd),
    .i_rr   (i_rr),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_r1   (o_r1),
    .o_r0   (o_r0),
    .o_c    (o_c),
    .o_z    (o_z)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, then flag and fractional rules. Returns {R, C, Z}.
  function automatic logic [17:0] ref_mul(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    longint   x;
    longint   y;
    longint   p;
    logic [15:0] pw;
    logic [15:0] r;
    logic        c;
    case (m[1:0])
      2'b01: begin x = longint'($signed(a)); y = longint'($signed(b)); end
      2'b10: begin x = longint'($signed(a)); y = longint'(b); end
      default: begin x = longint'(a); y = longint'(b); end
    endcase
    p  = x * y;
    pw = 16'(p);
    c  = pw[15];
    r  = m[2] ? 16'(pw << 1) : pw;
`ifdef FMUL_SAT_EN
    if (m == 3'b101 && a == 8'h80 && b == 8'h80) r = 16'h7FFF;
`endif
    return {r, c, (r == 16'h0000)};
  endfunction

  // Issue one request and wait for o_valid; lat counts edges after the accepting edge.
  task automatic do_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    i_mode  = m;
    i_rd    = a;
    i_rr    = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_mode  = 3'($urandom);
    i_rd    = 8'($urandom);
    i_rr    = 8'($urandom);
    lat = 0;
    while (!o_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid);
    end
    tests++;
    if ({o_r1, o_r0, o_c, o_z} !== 18'h0) begin
      fails++;
      $display("FAIL reset_out: got %h expected 0", {o_r1, o_r0, o_c, o_z});
    end
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  m[7]   = '{3'b000, 3'b110, 3'b101, 3'b001, 3'b100, 3'b000, 3'b011};
    logic [7:0]  a[7]   = '{8'hFF, 8'hC0, 8'h80, 8'h80, 8'h40, 8'h00, 8'hFF};
    logic [7:0]  b[7]   = '{8'hFF, 8'h80, 8'h80, 8'h80, 8'h40, 8'h5A, 8'h02};
    logic [17:0] exp[7];
    int lat;
    exp[0] = {16'hFE01, 1'b1, 1'b0};
    exp[1] = {16'hC000, 1'b1, 1'b0};
`ifdef FMUL_SAT_EN
    exp[2] = {16'h7FFF, 1'b0, 1'b0};
`else
    exp[2] = {16'h8000, 1'b0, 1'b0};
`endif
    exp[3] = {16'h4000, 1'b0, 1'b0};
    exp[4] = {16'h2000, 1'b0, 1'b0};
    exp[5] = {16'h0000, 1'b0, 1'b1};
    exp[6] = {16'h01FE, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      do_op(m[k], a[k], b[k], lat);
      tests++;
      if (lat != W) begin
        fails++;
        $display("FAIL dir_lat[%0d]: got %0d edges expected %0d", k, lat, W);
      end
      tests++;
      if ({o_r1, o_r0, o_c, o_z} !== exp[k]) begin
        fails++;
        $display("FAIL dir_res[%0d] mode=%b rd=%h rr=%h: got r=%h c=%b z=%b expected r=%h c=%b z=%b",
                 k, m[k], a[k], b[k], {o_r1, o_r0}, o_c, o_z, exp[k][17:2], exp[k][1], exp[k][0]);
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [7:0]  bnd[5] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01};
    logic [2:0]  m;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [17:0] exp;
    int lat;
    for (int k = 0; k < 40; k++) begin
      m = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 4)] : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 4)] : 8'($urandom);
      exp = ref_mul(m, a, b);
      do_op(m, a, b, lat);
      tests++;
      if (lat != W) begin
        fails++;
        $display("FAIL rnd_lat[%0d]: got %0d edges expected %0d", k, lat, W);
      end
      tests++;
      if ({o_r1, o_r0, o_c, o_z} !== exp) begin
        fails++;
        $display("FAIL rnd_res[%0d] mode=%b rd=%h rr=%h: got %h expected %h",
                 k, m, a, b, {o_r1, o_r0, o_c, o_z}, exp);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] snap;
    logic [17:0] exp;
    logic        bad;
    int lat;
    exp = ref_mul(3'b010, 8'hA5, 8'h3C);
    do_op(3'b010, 8'hA5, 8'h3C, lat);
    snap = {o_r1, o_r0, o_c, o_z};
    tests++;
    if (snap !== exp) begin
      fails++;
      $display("FAIL bp_res: got %h expected %h", snap, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        i_mode  = 3'b000;
        i_rd    = 8'h11;
        i_rr    = 8'h22;
        i_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      tests++;
      if ({o_r1, o_r0, o_c, o_z} !== exp || o_valid !== 1'b1 || o_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got r=%h valid=%b ready=%b expected r=%h valid=1 ready=0",
                 i, {o_r1, o_r0, o_c, o_z}, o_valid, o_ready, exp);
      end
    end
    consume();
    tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: valid=%b ready=%b expected valid=0 ready=1", o_valid, o_ready);
    end
    tests++;
    if ({o_r1, o_r0, o_c, o_z} !== exp) begin
      fails++;
      $display("FAIL bp_keep: got %h expected %h", {o_r1, o_r0, o_c, o_z}, exp);
    end
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL bp_ignored: spurious activity=%b expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    int lat;
    @(negedge clk);
    i_mode  = 3'b001;
    i_rd    = 8'h7F;
    i_rr    = 8'h7F;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || {o_r1, o_r0, o_c, o_z} !== 18'h0) begin
      fails++;
      $display("FAIL rst_mid: valid=%b ready=%b out=%h expected valid=0 ready=1 out=0",
               o_valid, o_ready, {o_r1, o_r0, o_c, o_z});
    end
    @(negedge clk);
    i_rst = 1'b0;
    bad = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_result: late activity=%b expected 0", bad);
    end
    do_op(3'b001, 8'h7F, 8'h7F, lat);
    tests++;
    if ({o_r1, o_r0, o_c, o_z} !== {16'h3F01, 1'b0, 1'b0} || lat != W) begin
      fails++;
      $display("FAIL rst_fresh: got r=%h c=%b z=%b lat=%0d expected r=3f01 c=0 z=0 lat=%0d",
               {o_r1, o_r0}, o_c, o_z, lat, W);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  m;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [17:0] exp;
    int first;
    int second;
    int seen;
    int n;
    m = 3'b110;
    a = 8'($urandom);
    b = 8'($urandom);
    exp = ref_mul(m, a, b);
    @(negedge clk);
    i_mode  = m;
    i_rd    = a;
    i_rr    = b;
    i_valid = 1'b1;
    i_ready = 1'b1;
    seen = 0;
    n = 0;
    first = -1;
    second = -1;
    while (seen < 2 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (o_valid) begin
        if (seen == 0) first = n;
        else second = n;
        seen++;
        tests++;
        if ({o_r1, o_r0, o_c, o_z} !== exp) begin
          fails++;
          $display("FAIL b2b_res[%0d]: got %h expected %h", seen, {o_r1, o_r0, o_c, o_z}, exp);
        end
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    tests++;
    if (seen != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d results expected 2", seen);
    end
    tests++;
    if (first != W + 1 || second - first != W + 2) begin
      fails++;
      $display("FAIL b2b_timing: first=%0d period=%0d expected first=%0d period=%0d",
               first, second - first, W + 1, W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
